// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative read-only instruction cache with tree-PLRU and miss FSM; optional flush walker enabled by ICACHE_FLUSH_EN
module icache_nway #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int s_way    = 2,
    parameter int s_tag    = 32 - s_offset - s_index,
    parameter int s_line   = 8 * (2 ** s_offset)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_address,
    input  logic              mem_read,
    output logic [s_line-1:0] mem_rdata256,
    output logic              mem_resp,
    output logic [31:0]       pmem_address,
    output logic              pmem_read,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp,
    input  logic              flush,
    output logic              flush_busy
);
    localparam int ways = 2 ** s_way;
    localparam int sets = 2 ** s_index;
    localparam int wb   = (s_way > 0) ? s_way : 1;

`ifdef ICACHE_FLUSH_EN
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH} state_t;
`else
    typedef enum logic {S_IDLE, S_FILL} state_t;
`endif

    state_t                r_state, w_next;
    logic [ways-1:0]       r_valid [sets];
    logic [s_tag-1:0]      r_tag   [ways][sets];
    logic [s_line-1:0]     r_data  [ways][sets];
    logic [31-s_offset:0]  r_miss_line;
    logic [s_index-1:0]    w_set, w_clr_set;
    logic [wb-1:0]         w_hit_way, w_inv_way, w_plru_way, w_victim;
    logic                  w_hit, w_has_inv, w_fill, w_clr, w_flush_req, w_unused;

`ifdef ICACHE_FLUSH_EN
    logic [s_index-1:0]    r_cnt;
    logic                  r_flush_pend;

    // Flush walk counter, and a flush request remembered while a fill is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_cnt        <= (r_state == S_FLUSH) ? r_cnt + 1'b1 : '0;
            r_flush_pend <= (r_state == S_FILL) && (flush || r_flush_pend);
        end
    end
    assign w_flush_req = flush || r_flush_pend;
    assign w_clr_set   = r_cnt;
    assign w_unused    = ^mem_address[s_offset-1:0];
`else
    assign w_flush_req = 1'b0;
    assign w_clr_set   = '0;
    assign w_unused    = ^{mem_address[s_offset-1:0], flush};
`endif

    // The set under lookup is the latched miss line while filling so the victim stays in the right set
    assign w_set        = (r_state == S_FILL) ? r_miss_line[s_index-1:0] : mem_address[s_offset +: s_index];
    assign w_victim     = w_has_inv ? w_inv_way : w_plru_way;
    assign mem_rdata256 = r_data[w_hit_way][w_set];
    assign pmem_address = {(r_state == S_FILL) ? r_miss_line : mem_address[31:s_offset], {s_offset{1'b0}}};

    // Tag compare across all ways and lowest-numbered invalid way of the set
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int i = ways - 1; i >= 0; i--) begin
            if (r_valid[w_set][i] && r_tag[i][w_set] == mem_address[31 -: s_tag]) begin
                w_hit     = 1'b1;
                w_hit_way = wb'(i);
            end
            if (!r_valid[w_set][i]) begin
                w_has_inv = 1'b1;
                w_inv_way = wb'(i);
            end
        end
    end

    // Next state and outputs; a flush request in idle takes priority over a pending fetch
    always_comb begin
        w_next     = r_state;
        w_fill     = 1'b0;
        w_clr      = 1'b0;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        flush_busy = 1'b0;
        case (r_state)
            S_IDLE: begin
                mem_resp = mem_read && w_hit && !w_flush_req;
                w_next   = (mem_read && !w_hit && !w_flush_req) ? S_FILL : S_IDLE;
`ifdef ICACHE_FLUSH_EN
                if (w_flush_req) w_next = S_FLUSH;
`endif
            end
            S_FILL: begin
                pmem_read = 1'b1;
                w_fill    = pmem_resp;
                w_next    = pmem_resp ? S_IDLE : S_FILL;
            end
`ifdef ICACHE_FLUSH_EN
            S_FLUSH: begin
                flush_busy = 1'b1;
                w_clr      = 1'b1;
                w_next     = (r_cnt == s_index'(sets - 1)) ? S_IDLE : S_FLUSH;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // State register and miss line capture while comparing
    always_ff @(posedge clk) begin
        r_state <= rst ? S_IDLE : w_next;
        if (r_state == S_IDLE) r_miss_line <= mem_address[31:s_offset];
    end

    // Valid bits: cleared by reset or the flush walk, set by a fill
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < sets; s++) r_valid[s] <= '0;
        end else if (w_clr) begin
            r_valid[w_clr_set] <= '0;
        end else if (w_fill) begin
            r_valid[w_set][w_victim] <= 1'b1;
        end
    end

    // Tag and data arrays are written only on fill and never cleared
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_victim][w_set]  <= r_miss_line[s_index +: s_tag];
            r_data[w_victim][w_set] <= pmem_rdata;
        end
    end

    generate
        if (s_way > 0) begin : g_plru
            logic [ways-2:0] r_plru [sets];
            logic [ways-2:0] w_upd;
            logic [wb-1:0]   w_way;

            assign w_way = w_fill ? w_victim : w_hit_way;

            // Walk the tree from the root following each node bit (1 = upper half) to find the victim
            always_comb begin
                int              n;
                logic [ways-2:0] t;
                n = 1;
                t = '0;
                for (int l = 0; l < s_way; l++) begin
                    t = r_plru[w_set] >> (n - 1);
                    n = 2 * n + int'(t[0]);
                end
                w_plru_way = wb'(n - ways);
            end

            // Point every node on the touched way's path away from that way
            always_comb begin
                int              n;
                logic [wb-1:0]   t;
                logic [ways-2:0] m;
                w_upd = r_plru[w_set];
                n     = 1;
                t     = '0;
                m     = '0;
                for (int l = 0; l < s_way; l++) begin
                    t     = w_way >> (s_way - 1 - l);
                    m     = (ways - 1)'(1) << (n - 1);
                    w_upd = t[0] ? (w_upd & ~m) : (w_upd | m);
                    n     = 2 * n + int'(t[0]);
                end
            end

            // PLRU state: cleared by reset or flush walk, updated on every hit and fill
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < sets; s++) r_plru[s] <= '0;
                end else if (w_clr) begin
                    r_plru[w_clr_set] <= '0;
                end else if (w_fill || mem_resp) begin
                    r_plru[w_set] <= w_upd;
                end
            end
        end else begin : g_dm
            assign w_plru_way = '0;
        end
    endgenerate
endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: directed scoreboard bench for icache_nway (4-way, 8 sets, 32-byte lines)
`timescale 1ns/1ps
module tb_icache_nway;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic [255:0] mem_rdata256;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         flush;
    logic         flush_busy;

    logic [255:0] exp_q[$];
    int           n_vec = 0;
    int           n_bad = 0;

`ifdef ICACHE_FLUSH_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    always #5 clk = ~clk;

    icache_nway dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read),
        .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .flush(flush), .flush_busy(flush_busy)
    );

    function automatic logic [255:0] pat(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: every mem_resp pops one expected line from the scoreboard
    always @(negedge clk) begin
        if (!rst && mem_resp) begin
            n_vec++;
            if (pmem_read) begin
                n_bad++;
                $display("FAIL resp_excl actual pmem_read=1 required 0");
            end
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_resp actual=%h required none", mem_rdata256);
            end else begin
                logic [255:0] e;
                e = exp_q.pop_front();
                if (mem_rdata256 !== e) begin
                    n_bad++;
                    $display("FAIL resp_data actual=%h required=%h", mem_rdata256, e);
                end
            end
        end
    end

    // One fetch; a miss is served by a pmem model answering lat cycles after pmem_read
    task automatic fetch(input logic [31:0] a, input bit miss, input int lat, input logic [255:0] d);
        int n, resp_at, req_at, wait_n;
        bit done, req;
        mem_address = a;
        mem_read    = 1'b1;
        exp_q.push_back(d);
        n = 0; resp_at = -1; req_at = -1; wait_n = 0; done = 1'b0; req = 1'b0;
        while (!done && n < 40) begin
            #1;
            if (mem_resp) begin
                done    = 1'b1;
                resp_at = n;
            end else if (pmem_read) begin
                if (!req) begin
                    req    = 1'b1;
                    req_at = n;
                    chk("pmem_addr", pmem_address, {a[31:5], 5'b0});
                end
                if (wait_n == lat) begin
                    pmem_rdata = d;
                    pmem_resp  = 1'b1;
                end
                wait_n++;
            end
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            n++;
        end
        mem_read = 1'b0;
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout addr=%h actual no mem_resp required mem_resp", a);
            void'(exp_q.pop_back());
        end else begin
            chk("resp_latency", resp_at, miss ? lat + 2 : 0);
        end
        chk("miss", req, miss);
        if (req) chk("pmem_req_cycle", req_at, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=hung required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b1; mem_read = 1'b1; mem_address = 32'h40;
        pmem_resp = 1'b0; pmem_rdata = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_resp", mem_resp, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_flush_busy", flush_busy, 0);
        mem_read = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        fetch(32'h0000_0040, 1'b1, 0, pat(8'hA5));
        fetch(32'h0000_0044, 1'b0, 0, pat(8'hA5));
        fetch(32'h0000_0140, 1'b1, 1, pat(8'h11));
        fetch(32'h0000_0240, 1'b1, 2, pat(8'h22));
        fetch(32'h0000_0340, 1'b1, 0, pat(8'h33));
        fetch(32'h0000_0040, 1'b0, 0, pat(8'hA5));
        fetch(32'h0000_0240, 1'b0, 0, pat(8'h22));
        fetch(32'h0000_0440, 1'b1, 0, pat(8'h44));
        fetch(32'h0000_0340, 1'b0, 0, pat(8'h33));
        fetch(32'h0000_0040, 1'b0, 0, pat(8'hA5));
        fetch(32'h0000_0240, 1'b0, 0, pat(8'h22));
        fetch(32'h0000_0440, 1'b0, 0, pat(8'h44));
        fetch(32'h0000_0140, 1'b1, 0, pat(8'h55));

        mem_address = 32'h0000_0080;
        mem_read    = 1'b1;
        @(posedge clk); #1;
        chk("abandon_pmem_read", pmem_read, 1);
        chk("abandon_pmem_addr", pmem_address, 32'h80);
        mem_read = 1'b0;
        @(posedge clk); #1;
        chk("abandon_hold_read", pmem_read, 1);
        pmem_rdata = pat(8'h66);
        pmem_resp  = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        chk("abandon_no_resp", mem_resp, 0);
        chk("abandon_read_drop", pmem_read, 0);
        repeat (2) @(posedge clk);
        #1;
        fetch(32'h0000_0080, 1'b0, 0, pat(8'h66));

        mem_address = 32'h0000_01C0;
        mem_read    = 1'b1;
        @(posedge clk); #1;
        chk("rstfill_pmem_read", pmem_read, 1);
        rst      = 1'b1;
        mem_read = 1'b0;
        @(posedge clk); #1;
        chk("rstfill_read_drop", pmem_read, 0);
        chk("rstfill_mem_resp", mem_resp, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        fetch(32'h0000_0040, 1'b1, 0, pat(8'h77));
        fetch(32'h0000_0080, 1'b1, 1, pat(8'h88));
        fetch(32'h0000_0440, 1'b1, 0, pat(8'h99));

        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        cnt = 0;
        while (flush_busy && cnt < 20) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("flush_busy_cycles", cnt, FL ? 8 : 0);
        fetch(32'h0000_0040, FL, 0, FL ? pat(8'hC1) : pat(8'h77));
        fetch(32'h0000_0080, FL, 0, FL ? pat(8'hC2) : pat(8'h88));
        fetch(32'h0000_0440, FL, 0, FL ? pat(8'hC3) : pat(8'h99));

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
